// File: rtl/popcount_acc_neuron.sv
// popcount_acc_neuron
// Accumulates signed (pos_cnt - neg_cnt) beats from a pair of 3-input
// popcount units over BEATS accepted beats. It then presents the final sum
// and an activation code through a valid/ready handshake.
// Optional feature macro: TERNARY_ACT_EN
//   defined     -> ternary activation {+1, 0, -1} using thr_hi / thr_lo
//   not defined -> binary activation {0, 1} using thr_hi only
module popcount_acc_neuron #(
    parameter int BEATS = 8,
    parameter int SUM_W = $clog2(3*BEATS+1)+1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       pos_cnt,
    input  logic [1:0]       neg_cnt,
    input  logic             flush,
    input  logic [SUM_W-1:0] thr_hi,
    input  logic [SUM_W-1:0] thr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [1:0]       out_act
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS+1) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS-1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic signed [SUM_W-1:0] acc, acc_nxt;
    logic signed [SUM_W-1:0] delta_p0;
    logic signed [SUM_W-1:0] sum_p0;
    logic signed [SUM_W-1:0] thr_hi_s;
    logic [SUM_W-1:0]        out_sum_nxt;
    logic [1:0]              out_act_nxt;

`ifdef TERNARY_ACT_EN
    logic signed [SUM_W-1:0] thr_lo_s;

    // +1 when at/above upper threshold (wins on overlap), -1 at/below lower, else 0
    function automatic logic [1:0] act_fn(input logic signed [SUM_W-1:0] s,
                                          input logic signed [SUM_W-1:0] hi,
                                          input logic signed [SUM_W-1:0] lo);
        if (s >= hi)
            return 2'b01;
        else if (s <= lo)
            return 2'b11;
        else
            return 2'b00;
    endfunction

    assign thr_lo_s = $signed(thr_lo);
`else
    // Lower threshold has no role in the binary activation
    logic unused_thr_lo;

    // 1 when at/above the upper threshold, else 0; upper bit is always 0
    function automatic logic [1:0] act_fn(input logic signed [SUM_W-1:0] s,
                                          input logic signed [SUM_W-1:0] hi);
        return {1'b0, (s >= hi)};
    endfunction

    assign unused_thr_lo = ^thr_lo;
`endif

    // Beat difference is -3..+3; zero-extend both counts then subtract at full width
    assign delta_p0 = $signed({{(SUM_W-2){1'b0}}, pos_cnt})
                    - $signed({{(SUM_W-2){1'b0}}, neg_cnt});
    assign sum_p0   = acc + delta_p0;
    assign thr_hi_s = $signed(thr_hi);

    // Next-state, accumulator and result selection; handshake outputs decode state only
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        out_sum_nxt = out_sum;
        out_act_nxt = out_act;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (flush) begin
                    // Abort wins over a same-cycle beat, which is dropped
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end else if (in_valid) begin
                    if (cnt == LAST_BEAT) begin
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                        out_sum_nxt = sum_p0;
`ifdef TERNARY_ACT_EN
                        out_act_nxt = act_fn(sum_p0, thr_hi_s, thr_lo_s);
`else
                        out_act_nxt = act_fn(sum_p0, thr_hi_s);
`endif
                        state_nxt   = HOLD;
                    end else begin
                        acc_nxt = sum_p0;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = ACC;
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Control state: FSM and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Running sum and registered result; reset discards any partial or pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            out_sum <= '0;
            out_act <= 2'b00;
        end else begin
            acc     <= acc_nxt;
            out_sum <= out_sum_nxt;
            out_act <= out_act_nxt;
        end
    end

endmodule

// File: tb/tb_popcount_acc_neuron.sv
// Self-checking bench for popcount_acc_neuron: a table of full evaluations
// plus hand-written sequences for stall, gaps, flush, reset and thresholds.
module tb_popcount_acc_neuron;

    localparam int BEATS = 8;
    localparam int SUM_W = $clog2(3*BEATS+1)+1;
`ifdef TERNARY_ACT_EN
    localparam bit TERN = 1'b1;
`else
    localparam bit TERN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       pos_cnt = 2'd0;
    logic [1:0]       neg_cnt = 2'd0;
    logic             flush = 1'b0;
    logic [SUM_W-1:0] thr_hi = '0;
    logic [SUM_W-1:0] thr_lo = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] out_sum;
    logic [1:0]       out_act;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sum;
        logic [1:0] act;
    } exp_t;

    typedef struct {
        logic [1:0] pos;
        logic [1:0] neg;
        int         hi;
        int         lo;
        int         sum;
        logic [1:0] act_bin;
        logic [1:0] act_ter;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    popcount_acc_neuron #(.BEATS(BEATS), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .flush(flush),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act)
    );

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic push_exp(input int s, input logic [1:0] ab, input logic [1:0] at);
        exp_t e;
        e.sum = s;
        e.act = TERN ? at : ab;
        sb.push_back(e);
    endtask

    // Presents one beat and returns #1 after the edge that accepted it
    task automatic drive_beat(input logic [1:0] p, input logic [1:0] n);
        int t;
        t = 0;
        pos_cnt  = p;
        neg_cnt  = n;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        pos_cnt  = 2'd3;
        neg_cnt  = 2'd0;
        @(posedge clk); #1;
    endtask

    // Scoreboard: compare on every completed result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_sum", $signed(out_sum), e.sum);
                check("out_act", int'(out_act), int'(e.act));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd3, 2'd0,  20, -10,  24, 2'b01, 2'b01};
        tbl[1] = '{2'd0, 2'd3,   0, -10, -24, 2'b00, 2'b11};
        tbl[2] = '{2'd2, 2'd1,   8,  -3,   8, 2'b01, 2'b01};
        tbl[3] = '{2'd1, 2'd2,  -7,  -8,  -8, 2'b00, 2'b11};
        tbl[4] = '{2'd1, 2'd1,   0,  -1,   0, 2'b01, 2'b01};
        tbl[5] = '{2'd2, 2'd2,   1,   0,   0, 2'b00, 2'b11};
        tbl[6] = '{2'd3, 2'd3,   1,   1,   0, 2'b00, 2'b11};
        tbl[7] = '{2'd3, 2'd1,  16,  16,  16, 2'b01, 2'b01};
        tbl[8] = '{2'd0, 2'd1,  -8,  -8,  -8, 2'b01, 2'b01};

        // Reset state
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sum", $signed(out_sum), 0);
        check("reset_out_act", int'(out_act), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_in_ready", int'(in_ready), 1);

        // Table of full evaluations with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            thr_hi = SUM_W'(tbl[i].hi);
            thr_lo = SUM_W'(tbl[i].lo);
            push_exp(tbl[i].sum, tbl[i].act_bin, tbl[i].act_ter);
            for (int b = 0; b < BEATS; b++) begin
                if (b == BEATS-1) check("no_early_valid", int'(out_valid), 0);
                drive_beat(tbl[i].pos, tbl[i].neg);
            end
            check("latency_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
            check("ready_after_hs", int'(in_ready), 1);
            check("valid_after_hs", int'(out_valid), 0);
        end

        // Stall: result held for 5 cycles, offered beats must be ignored
        out_ready = 1'b0;
        thr_hi = SUM_W'(0);
        thr_lo = SUM_W'(-10);
        push_exp(-24, 2'b00, 2'b11);
        for (int b = 0; b < BEATS; b++) drive_beat(2'd0, 2'd3);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            pos_cnt  = 2'd3;
            neg_cnt  = 2'd0;
            check("stall_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_sum", $signed(out_sum), -24);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_ready", int'(in_ready), 1);

        // Gaps between beats must not advance the count
        thr_hi = SUM_W'(0);
        push_exp(4, 2'b01, 2'b01);
        for (int b = 0; b < BEATS; b++) begin
            if (b[0]) drive_beat(2'd1, 2'd1);
            else      drive_beat(2'd2, 2'd1);
            if (b != BEATS-1) begin
                idle_cycle();
                check("gap_no_valid", int'(out_valid), 0);
            end
        end
        check("gap_valid", int'(out_valid), 1);
        @(posedge clk); #1;

        // Flush after 3 beats, alongside a 4th beat that must be dropped
        thr_hi = SUM_W'(5);
        push_exp(8, 2'b01, 2'b01);
        for (int b = 0; b < 3; b++) drive_beat(2'd3, 2'd0);
        pos_cnt  = 2'd3;
        neg_cnt  = 2'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b == BEATS-1) check("flush_no_early_valid", int'(out_valid), 0);
            drive_beat(2'd1, 2'd0);
        end
        check("flush_valid", int'(out_valid), 1);
        @(posedge clk); #1;

        // Reset mid-HOLD discards the pending result immediately
        out_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) drive_beat(2'd3, 2'd0);
        check("pre_reset_valid", int'(out_valid), 1);
        check("pre_reset_sum", $signed(out_sum), 24);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", int'(out_valid), 0);
        check("async_reset_sum", $signed(out_sum), 0);
        check("async_reset_act", int'(out_act), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Reset mid-evaluation discards the partial sum
        for (int b = 0; b < 3; b++) drive_beat(2'd3, 2'd0);
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        thr_hi = SUM_W'(-8);
        thr_lo = SUM_W'(-20);
        push_exp(-8, 2'b01, 2'b01);
        for (int b = 0; b < BEATS; b++) drive_beat(2'd0, 2'd1);
        check("fresh_valid", int'(out_valid), 1);
        @(posedge clk); #1;

        // Thresholds matter only on the final beat: 30 in between, 5 at the end
        thr_lo = SUM_W'(-10);
        push_exp(6, 2'b01, 2'b01);
        for (int b = 0; b < BEATS; b++) begin
            thr_hi = (b == 3) ? SUM_W'(30) : ((b == BEATS-1) ? SUM_W'(5) : thr_hi);
            if (b < 6) drive_beat(2'd1, 2'd0);
            else       drive_beat(2'd0, 2'd0);
        end
        @(posedge clk); #1;

        // Inverse: 5 in between, 30 at the end
        push_exp(6, 2'b00, 2'b00);
        for (int b = 0; b < BEATS; b++) begin
            thr_hi = (b == BEATS-1) ? SUM_W'(30) : SUM_W'(5);
            if (b < 6) drive_beat(2'd1, 2'd0);
            else       drive_beat(2'd0, 2'd0);
        end
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
